// File: rtl/loop_seq_pkg.sv
// ---------------------------------------------------------------------------
// loop_seq_pkg
// Shared types and sizes for the loop_sequencer record/playback controller:
// FSM state encoding, SRAM geometry and a small step-position helper.
// No ports (package).
// ---------------------------------------------------------------------------
package loop_seq_pkg;

   localparam int SEQ_DEPTH = 16;   // SRAM entries
   localparam int ADDR_W    = 4;    // SRAM address width
   localparam int MASK_W    = 12;   // one bit per key
   localparam int LEN_W     = 5;    // holds 0..SEQ_DEPTH

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_REC       = 3'd1,
      ST_PLAY_RD   = 3'd2,
      ST_PLAY_HOLD = 3'd3,
      ST_DONE      = 3'd4
   } loop_seq_state_t;

   // True when step is the final recorded step of a len-step sequence.
   function automatic logic is_last_step(input logic [ADDR_W-1:0] step,
                                         input logic [LEN_W-1:0]  len);
      return ({1'b0, step} == (len - 5'd1));
   endfunction

endpackage

// File: rtl/loop_sequencer_if.sv
// ---------------------------------------------------------------------------
// loop_sequencer_if
// Bundles the control inputs, SRAM port and status outputs of loop_sequencer.
//   master : sequencer side (drives SRAM port, tone enables, status)
//   slave  : environment side (drives requests, key mask, SRAM read data)
// Signals: rec_req, play_req, stop, rec_commit, key_mask[11:0],
//          mem_addr[3:0], mem_we, mem_wdata[11:0], mem_rdata[11:0],
//          tone_en[11:0], seq_len[4:0], cur_step[3:0], recording, playing, full
// ---------------------------------------------------------------------------
interface loop_sequencer_if;
   import loop_seq_pkg::*;

   logic                rec_req;
   logic                play_req;
   logic                stop;
   logic                rec_commit;
   logic [MASK_W-1:0]   key_mask;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_we;
   logic [MASK_W-1:0]   mem_wdata;
   logic [MASK_W-1:0]   mem_rdata;
   logic [MASK_W-1:0]   tone_en;
   logic [LEN_W-1:0]    seq_len;
   logic [ADDR_W-1:0]   cur_step;
   logic                recording;
   logic                playing;
   logic                full;

   modport master (
      input  rec_req, play_req, stop, rec_commit, key_mask, mem_rdata,
      output mem_addr, mem_we, mem_wdata, tone_en, seq_len, cur_step,
             recording, playing, full
   );

   modport slave (
      output rec_req, play_req, stop, rec_commit, key_mask, mem_rdata,
      input  mem_addr, mem_we, mem_wdata, tone_en, seq_len, cur_step,
             recording, playing, full
   );

endinterface

// File: rtl/step_timer.sv
// ---------------------------------------------------------------------------
// step_timer
// Playback hold counter. load_i clears the count, en_i advances it, tc_o
// flags the final hold cycle (count == STEP_CYCLES-1) while enabled.
// Ports: clk_i, rst_i (async, active high), load_i, en_i, tc_o
// ---------------------------------------------------------------------------
module step_timer #(
   parameter int STEP_CYCLES = 5_000_000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic en_i,
   output logic tc_o
);

   // A one-cycle hold still needs a 1-bit counter.
   localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(STEP_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;

   // Hold counter: clear on load, advance while enabled.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= {CNT_W{1'b0}};
      end else if (load_i) begin
         cnt_q <= {CNT_W{1'b0}};
      end else if (en_i) begin
         cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_q <= cnt_q;
      end
   end

   assign tc_o = en_i && (cnt_q == TC_VAL);

endmodule

// File: rtl/loop_sequencer.sv
// ---------------------------------------------------------------------------
// loop_sequencer
// Record/playback owner of the 16 x 12-bit key-pattern SRAM. REC writes
// committed key masks to consecutive addresses; PLAY steps through them,
// holding each mask on tone_en for STEP_CYCLES+1 cycles.
// Ports: CLK, RST (async, active high), bus (loop_sequencer_if.master)
// Build option: LOOP_SEQ_REPEAT_EN -- loop playback until stop/play_req
// drops; undefined gives one-shot playback ending in DONE.
// ---------------------------------------------------------------------------
module loop_sequencer
   import loop_seq_pkg::*;
#(
   parameter int STEP_CYCLES = 5_000_000
) (
   input  logic                    CLK,
   input  logic                    RST,
   loop_sequencer_if.master        bus
);

   loop_seq_state_t     state_q,     state_d;
   logic [ADDR_W-1:0]   step_q,      step_d;
   logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
   logic                mem_we_q,    mem_we_d;
   logic [MASK_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic [MASK_W-1:0]   tone_en_q,   tone_en_d;
   logic [LEN_W-1:0]    seq_len_q,   seq_len_d;
   logic [ADDR_W-1:0]   cur_step_q,  cur_step_d;
   logic                recording_q, recording_d;
   logic                playing_q,   playing_d;
   logic                full_q,      full_d;
   logic                tmr_load_s;
   logic                tmr_en_s;
   logic                tmr_tc_s;

   assign tmr_load_s = (state_q == ST_PLAY_RD);
   assign tmr_en_s   = (state_q == ST_PLAY_HOLD);

   step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_step_timer (
      .clk_i  (CLK),
      .rst_i  (RST),
      .load_i (tmr_load_s),
      .en_i   (tmr_en_s),
      .tc_o   (tmr_tc_s)
   );

   // Next-state and next-output computation for the sequencer FSM.
   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = 1'b0;
      mem_wdata_d = {MASK_W{1'b0}};
      tone_en_d   = tone_en_q;
      cur_step_d  = cur_step_q;
      // A write in flight this cycle lands in seq_len at this edge, so
      // seq_len_d is also the address for a back-to-back commit.
      seq_len_d   = seq_len_q + {{(LEN_W-1){1'b0}}, mem_we_q};

      if (bus.stop) begin
         state_d    = ST_IDLE;
         tone_en_d  = {MASK_W{1'b0}};
         step_d     = {ADDR_W{1'b0}};
         mem_addr_d = {ADDR_W{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.rec_req) begin
                  state_d   = ST_REC;
                  seq_len_d = {LEN_W{1'b0}};
               end else if (bus.play_req && (seq_len_q != {LEN_W{1'b0}})) begin
                  state_d    = ST_PLAY_RD;
                  step_d     = {ADDR_W{1'b0}};
                  mem_addr_d = {ADDR_W{1'b0}};
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_REC: begin
               if (!bus.rec_req) begin
                  state_d    = ST_IDLE;
                  mem_addr_d = {ADDR_W{1'b0}};
               end else if (bus.rec_commit && (seq_len_d != LEN_W'(SEQ_DEPTH))) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = seq_len_d[ADDR_W-1:0];
                  mem_wdata_d = bus.key_mask;
               end else begin
                  state_d = ST_REC;
               end
            end
            ST_PLAY_RD: begin
               tone_en_d  = bus.mem_rdata;
               cur_step_d = step_q;
               state_d    = ST_PLAY_HOLD;
            end
            ST_PLAY_HOLD: begin
               if (tmr_tc_s) begin
`ifdef LOOP_SEQ_REPEAT_EN
                  if (!bus.play_req) begin
                     state_d    = ST_IDLE;
                     tone_en_d  = {MASK_W{1'b0}};
                     step_d     = {ADDR_W{1'b0}};
                     mem_addr_d = {ADDR_W{1'b0}};
                  end else if (is_last_step(step_q, seq_len_q)) begin
                     state_d    = ST_PLAY_RD;
                     step_d     = {ADDR_W{1'b0}};
                     mem_addr_d = {ADDR_W{1'b0}};
                  end else begin
                     state_d    = ST_PLAY_RD;
                     step_d     = step_q + 4'd1;
                     mem_addr_d = step_q + 4'd1;
                  end
`else
                  if (is_last_step(step_q, seq_len_q)) begin
                     state_d    = ST_DONE;
                     tone_en_d  = {MASK_W{1'b0}};
                     step_d     = {ADDR_W{1'b0}};
                     mem_addr_d = {ADDR_W{1'b0}};
                  end else begin
                     state_d    = ST_PLAY_RD;
                     step_d     = step_q + 4'd1;
                     mem_addr_d = step_q + 4'd1;
                  end
`endif
               end else begin
                  state_d = ST_PLAY_HOLD;
               end
            end
            ST_DONE: begin
               tone_en_d = {MASK_W{1'b0}};
               if (!bus.play_req) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DONE;
               end
            end
            default: begin
               state_d    = ST_IDLE;
               tone_en_d  = {MASK_W{1'b0}};
               mem_addr_d = {ADDR_W{1'b0}};
            end
         endcase
      end

      recording_d = (state_d == ST_REC);
      playing_d   = (state_d == ST_PLAY_RD) || (state_d == ST_PLAY_HOLD);
      full_d      = (seq_len_d == LEN_W'(SEQ_DEPTH));
   end

   // State and registered output update; reset forces outputs immediately.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         step_q      <= {ADDR_W{1'b0}};
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_we_q    <= 1'b0;
         mem_wdata_q <= {MASK_W{1'b0}};
         tone_en_q   <= {MASK_W{1'b0}};
         seq_len_q   <= {LEN_W{1'b0}};
         cur_step_q  <= {ADDR_W{1'b0}};
         recording_q <= 1'b0;
         playing_q   <= 1'b0;
         full_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         mem_addr_q  <= mem_addr_d;
         mem_we_q    <= mem_we_d;
         mem_wdata_q <= mem_wdata_d;
         tone_en_q   <= tone_en_d;
         seq_len_q   <= seq_len_d;
         cur_step_q  <= cur_step_d;
         recording_q <= recording_d;
         playing_q   <= playing_d;
         full_q      <= full_d;
      end
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.tone_en   = tone_en_q;
   assign bus.seq_len   = seq_len_q;
   assign bus.cur_step  = cur_step_q;
   assign bus.recording = recording_q;
   assign bus.playing   = playing_q;
   assign bus.full      = full_q;

endmodule

// File: tb/tb_loop_sequencer.sv
// ---------------------------------------------------------------------------
// tb_loop_sequencer
// Directed bench for loop_sequencer with STEP_CYCLES=4 and a behavioural
// SRAM (write on clock edge, combinational read). Honors LOOP_SEQ_REPEAT_EN.
// ---------------------------------------------------------------------------
module tb_loop_sequencer;
   import loop_seq_pkg::*;

   localparam int STEP = 4;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   // Free-running clock, period 10.
   always #5 CLK = ~CLK;

   loop_sequencer_if bus ();

   loop_sequencer #(.STEP_CYCLES(STEP)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   logic [11:0] sram [16];

   // Behavioural SRAM write port.
   always @(posedge CLK) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_wdata;
   end

   assign bus.mem_rdata = sram[bus.mem_addr];

   typedef struct {
      logic        rec, play, stp, cmt;
      logic [11:0] mask;
      logic        we;
      logic [3:0]  addr;
      logic [11:0] wdata, tone;
      logic [4:0]  len;
      logic        recg, plyg;
   } vec_t;

   vec_t vq[$];
   int   checks   = 0;
   int   failures = 0;
   logic [11:0] pats [3] = '{12'h001, 12'h0F0, 12'h800};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic rec, input logic play, input logic stp, input logic cmt,
                      input logic [11:0] mask, input logic we, input logic [3:0] addr,
                      input logic [11:0] wdata, input logic [11:0] tone,
                      input logic [4:0] len, input logic recg, input logic plyg);
      vec_t v;
      v.rec = rec; v.play = play; v.stp = stp; v.cmt = cmt; v.mask = mask;
      v.we = we; v.addr = addr; v.wdata = wdata; v.tone = tone;
      v.len = len; v.recg = recg; v.plyg = plyg;
      vq.push_back(v);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) sram[i] = 12'h000;
      bus.rec_req = 1'b0; bus.play_req = 1'b0; bus.stop = 1'b0;
      bus.rec_commit = 1'b0; bus.key_mask = 12'h000;

      // ---------------- vector table ----------------
      add(1'b1,1'b0,1'b0,1'b0,12'h000, 1'b0,4'd0,12'h000, 12'h000,5'd0,1'b1,1'b0);
      add(1'b1,1'b0,1'b0,1'b1,12'h001, 1'b1,4'd0,12'h001, 12'h000,5'd0,1'b1,1'b0);
      add(1'b1,1'b0,1'b0,1'b1,12'h0F0, 1'b1,4'd1,12'h0F0, 12'h000,5'd1,1'b1,1'b0);
      add(1'b1,1'b0,1'b0,1'b1,12'h800, 1'b1,4'd2,12'h800, 12'h000,5'd2,1'b1,1'b0);
      add(1'b1,1'b0,1'b0,1'b0,12'h000, 1'b0,4'd0,12'h000, 12'h000,5'd3,1'b1,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,12'h000, 1'b0,4'd0,12'h000, 12'h000,5'd3,1'b0,1'b0);
      // play_req sampled -> PLAY_RD, tone not yet updated
      add(1'b0,1'b1,1'b0,1'b0,12'h000, 1'b0,4'd0,12'h000, 12'h000,5'd3,1'b0,1'b1);
`ifdef LOOP_SEQ_REPEAT_EN
      for (int s = 0; s < 3; s++)
         for (int k = 0; k < 5; k++)
            add(1'b0,1'b1,1'b0,1'b0,12'h000, 1'b0,4'd0,12'h000, pats[s],5'd3,1'b0,1'b1);
      // wrapped back to step 0; drop play_req during its hold
      add(1'b0,1'b1,1'b0,1'b0,12'h000, 1'b0,4'd0,12'h000, 12'h001,5'd3,1'b0,1'b1);
      for (int k = 0; k < 3; k++)
         add(1'b0,1'b0,1'b0,1'b0,12'h000, 1'b0,4'd0,12'h000, 12'h001,5'd3,1'b0,1'b1);
      add(1'b0,1'b0,1'b0,1'b0,12'h000, 1'b0,4'd0,12'h000, 12'h000,5'd3,1'b0,1'b0);
`else
      for (int s = 0; s < 3; s++)
         for (int k = 0; k < 5; k++)
            if (s == 2 && k == 4)
               add(1'b0,1'b1,1'b0,1'b0,12'h000, 1'b0,4'd0,12'h000, 12'h000,5'd3,1'b0,1'b0);
            else
               add(1'b0,1'b1,1'b0,1'b0,12'h000, 1'b0,4'd0,12'h000, pats[s],5'd3,1'b0,1'b1);
      // DONE holds while play_req stays high, then IDLE
      add(1'b0,1'b1,1'b0,1'b0,12'h000, 1'b0,4'd0,12'h000, 12'h000,5'd3,1'b0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,12'h000, 1'b0,4'd0,12'h000, 12'h000,5'd3,1'b0,1'b0);
`endif
      // replay, then stop mid-hold
      add(1'b0,1'b1,1'b0,1'b0,12'h000, 1'b0,4'd0,12'h000, 12'h000,5'd3,1'b0,1'b1);
      add(1'b0,1'b1,1'b0,1'b0,12'h000, 1'b0,4'd0,12'h000, 12'h001,5'd3,1'b0,1'b1);
      add(1'b0,1'b1,1'b1,1'b0,12'h000, 1'b0,4'd0,12'h000, 12'h000,5'd3,1'b0,1'b0);
      add(1'b0,1'b0,1'b0,1'b0,12'h000, 1'b0,4'd0,12'h000, 12'h000,5'd3,1'b0,1'b0);

      // ---------------- reset state ----------------
      #2 RST = 1'b1;
      #1;
      chk("rst_tone", 32'(bus.tone_en), 32'h0);
      chk("rst_len", 32'(bus.seq_len), 32'h0);
      chk("rst_we", 32'(bus.mem_we), 32'h0);
      chk("rst_status", 32'({bus.recording, bus.playing, bus.full}), 32'h0);
      repeat (2) @(posedge CLK);
      @(negedge CLK) RST = 1'b0;

      // ---------------- table-driven run ----------------
      foreach (vq[i]) begin
         bus.rec_req    = vq[i].rec;
         bus.play_req   = vq[i].play;
         bus.stop       = vq[i].stp;
         bus.rec_commit = vq[i].cmt;
         bus.key_mask   = vq[i].mask;
         tick();
         chk($sformatf("v%0d_we", i), 32'(bus.mem_we), 32'(vq[i].we));
         if (vq[i].we) begin
            chk($sformatf("v%0d_addr", i), 32'(bus.mem_addr), 32'(vq[i].addr));
         end
         chk($sformatf("v%0d_wdata", i), 32'(bus.mem_wdata), 32'(vq[i].wdata));
         chk($sformatf("v%0d_tone", i), 32'(bus.tone_en), 32'(vq[i].tone));
         chk($sformatf("v%0d_len", i), 32'(bus.seq_len), 32'(vq[i].len));
         chk($sformatf("v%0d_rec", i), 32'(bus.recording), 32'(vq[i].recg));
         chk($sformatf("v%0d_play", i), 32'(bus.playing), 32'(vq[i].plyg));
      end
      bus.rec_req = 1'b0; bus.play_req = 1'b0; bus.stop = 1'b0; bus.rec_commit = 1'b0;

      // ---------------- reset during PLAY_HOLD ----------------
      bus.play_req = 1'b1;
      repeat (3) tick();
      chk("prerst_tone", 32'(bus.tone_en), 32'h001);
      chk("prerst_step", 32'(bus.cur_step), 32'h0);
      #2 RST = 1'b1;
      #1;
      chk("midrst_tone", 32'(bus.tone_en), 32'h0);
      chk("midrst_len", 32'(bus.seq_len), 32'h0);
      chk("midrst_play", 32'(bus.playing), 32'h0);
      chk("midrst_addr", 32'(bus.mem_addr), 32'h0);
      @(negedge CLK) RST = 1'b0;

      // ---------------- play request with empty memory ----------------
      tick();
      chk("empty_play", 32'(bus.playing), 32'h0);
      tick();
      chk("empty_tone", 32'(bus.tone_en), 32'h0);

      // ---------------- rec_req wins over play_req ----------------
      bus.rec_req = 1'b1;
      tick();
      chk("both_rec", 32'(bus.recording), 32'h1);
      chk("both_play", 32'(bus.playing), 32'h0);
      bus.play_req = 1'b0;

      // ---------------- 17 back-to-back commits ----------------
      for (int k = 0; k < 17; k++) begin
         bus.rec_commit = 1'b1;
         bus.key_mask   = 12'h100 + 12'(k);
         tick();
         if (k < 16) begin
            chk($sformatf("b2b%0d_we", k), 32'(bus.mem_we), 32'h1);
            chk($sformatf("b2b%0d_addr", k), 32'(bus.mem_addr), 32'(k));
            chk($sformatf("b2b%0d_wdata", k), 32'(bus.mem_wdata), 32'h100 + 32'(k));
         end else begin
            chk("b2b16_we", 32'(bus.mem_we), 32'h0);
            chk("b2b16_full", 32'(bus.full), 32'h1);
         end
      end
      bus.rec_commit = 1'b0;
      tick();
      chk("b2b_len", 32'(bus.seq_len), 32'd16);
      chk("b2b_full", 32'(bus.full), 32'h1);
      chk("b2b_sram15", 32'(sram[15]), 32'h10F);
      chk("b2b_sram0", 32'(sram[0]), 32'h100);
      bus.rec_req = 1'b0;
      tick();
      chk("b2b_exit_rec", 32'(bus.recording), 32'h0);
      chk("b2b_exit_len", 32'(bus.seq_len), 32'd16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/loop_sequencer.md
# loop_sequencer

Record/playback controller for the 16-entry × 12-bit key-pattern SRAM. In record mode it writes successive 12-key masks, taken from the key accumulator, into consecutive SRAM addresses. In play mode it steps through the recorded addresses at a fixed tempo and drives the 12 per-key tone-converter enables. It replaces ad-hoc address/RW gating around the SRAM with one sequenced owner of the memory port.

## Interface
Parameters:
- STEP_CYCLES, 5_000_000, HOLD cycles per playback step; legal range ≥1.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  asynchronous, active-high reset.
- rec_req  in  1  level; request record mode.
- play_req  in  1  level; request play mode.
- stop  in  1  pulse/level; return to IDLE.
- rec_commit  in  1  single-cycle pulse; store key_mask as the next step.
- key_mask  in  12  accumulated key pattern, bit n = key n.
- mem_addr  out  4  SRAM address.
- mem_we  out  1  SRAM write strobe, 1 = write.
- mem_wdata  out  12  SRAM write data.
- mem_rdata  in  12  SRAM read data; valid the cycle after mem_addr is presented.
- tone_en  out  12  per-key tone enables.
- seq_len  out  5  number of recorded steps, 0..16.
- cur_step  out  4  step currently sounding.
- recording  out  1  high in REC.
- playing  out  1  high in PLAY_RD or PLAY_HOLD.
- full  out  1  seq_len == 16.

## Operation
- States: IDLE, REC, PLAY_RD, PLAY_HOLD, DONE.
- IDLE:
  - rec_req=1 → REC; seq_len is cleared to 0 on entry.
  - Else play_req=1 and seq_len>0 → PLAY_RD with step=0.
  - play_req with seq_len=0 is ignored.
  - rec_req takes priority over play_req.
- REC:
  - On rec_commit with seq_len<16: for one cycle, mem_we=1, mem_addr=seq_len[3:0], mem_wdata=key_mask; then seq_len+1.
  - rec_commit when full is ignored; no write occurs.
  - Leaving REC: rec_req=0 → IDLE.
- PLAY_RD:
  - mem_addr=step and mem_we=0 for one cycle.
  - Next edge: tone_en←mem_rdata, cur_step←step, hold counter←0, → PLAY_HOLD.
- PLAY_HOLD:
  - The counter increments each cycle.
  - At count STEP_CYCLES-1: if step==seq_len-1, go to end-of-sequence handling (see Configuration); otherwise step+1 → PLAY_RD.
  - tone_en stays stable through the following PLAY_RD cycle, so there is no gap between steps.
- DONE: tone_en=0; play_req=0 → IDLE. This prevents immediate retrigger.
- stop=1 in any state → IDLE on the next edge, tone_en=0; seq_len is kept.
  - stop has priority over every other input.
- Outside the REC write cycle, mem_we=0 and mem_wdata=0.

## Timing
- Reset values: state=IDLE, tone_en=0, mem_addr=0, mem_we=0, mem_wdata=0, seq_len=0, cur_step=0, recording=0, playing=0, full=0.
  - SRAM contents are untouched; seq_len=0 marks the memory empty.
- Write latency: rec_commit at cycle N → mem_we high during cycle N+1; seq_len updates at the end of cycle N+1.
  - A second rec_commit during cycle N+1 is accepted, giving one write per cycle.
- Play start: play_req sampled at edge E → PLAY_RD in cycle E+1 → tone_en valid from edge E+2.
- Step period: exactly STEP_CYCLES+1 cycles between tone_en updates.
- All status outputs are registered and derived from state.
- Reset asserted mid-write or mid-play: outputs are forced to reset values asynchronously.

## Configuration
- LOOP_SEQ_REPEAT_EN, when defined: after the last step, step wraps to 0 → PLAY_RD; playback loops until stop or until play_req falls.
  - play_req=0 in PLAY_HOLD ends playback at the step boundary → IDLE.
- When undefined: after the last step → DONE (one-shot playback); the level of play_req during playback is ignored.

## Structure
- Package loop_seq_pkg holds:
  - state enum loop_seq_state_t;
  - SEQ_DEPTH=16, ADDR_W=4, MASK_W=12, LEN_W=5.
- Sub-module step_timer provides the HOLD counter: load, enable, and a terminal-count pulse at STEP_CYCLES-1, with counter width derived via $clog2(STEP_CYCLES).
- The FSM, address/step registers and output registers live in loop_sequencer.

## Test plan
All scenarios use STEP_CYCLES=4.
- Reset, then rec_req=1 and three commits with masks 0x001, 0x0F0, 0x800 → writes at addr 0, 1, 2 with matching wdata; seq_len=3.
- 17 back-to-back commits in REC → 16 writes (addr 0..15); full=1; 17th commit produces no mem_we.
- Play after the first test (macro undefined) → tone_en=0x001, 0x0F0, 0x800, each held 5 cycles, first update 2 cycles after play_req; then DONE with tone_en=0.
- Same with LOOP_SEQ_REPEAT_EN → sequence 0x001, 0x0F0, 0x800, 0x001…; play_req drop → IDLE at the next step boundary.
- stop pulse mid-HOLD → IDLE next cycle, tone_en=0, seq_len still 3; play_req with seq_len=0 after reset → stays IDLE.
- rec_req and play_req both raised in IDLE → REC; RST pulsed during PLAY_HOLD → all outputs 0 immediately.
